// File: rtl/jtbubl_obj_draw_if.sv
// Bundle of request, ROM and line-buffer signals for the object tile-row drawer.
// The master side issues draw requests and serves ROM reads; the slave side is the drawer.
interface jtbubl_obj_draw_if #(
    parameter int CW  = 10,
    parameter int PW  = 4,
    parameter int BPP = 4,
    parameter int LAW = 9
);
    // Handshakes: a request transfers on any rising edge where req=1 and full=0
    // (req while full is dropped). ROM: rom_cs=1 holds rom_addr stable until a
    // cycle with rom_ok=1 after the first one; rom_data is taken on that cycle.
    // buf_we is a single-cycle write strobe with no back-pressure.
    logic            req;
    logic [CW-1:0]   req_code;
    logic [PW-1:0]   req_pal;
    logic            req_hflip;
    logic            req_vflip;
    logic [2:0]      req_vrow;
    logic [LAW-1:0]  req_xpos;
    logic            req_cont;
    logic            full;
    logic            busy;
    logic            rom_cs;
    logic [CW+2:0]   rom_addr;
    logic [8*BPP-1:0] rom_data;
    logic            rom_ok;
    logic            buf_we;
    logic [LAW-1:0]  buf_addr;
    logic [PW+BPP-1:0] buf_din;
    logic [1:0]      fsm_state;

    modport master (
        output req, req_code, req_pal, req_hflip, req_vflip, req_vrow, req_xpos, req_cont,
        output rom_data, rom_ok,
        input  full, busy, rom_cs, rom_addr, buf_we, buf_addr, buf_din, fsm_state
    );

    modport slave (
        input  req, req_code, req_pal, req_hflip, req_vflip, req_vrow, req_xpos, req_cont,
        input  rom_data, rom_ok,
        output full, busy, rom_cs, rom_addr, buf_we, buf_addr, buf_din, fsm_state
    );
endinterface

// File: rtl/jtbubl_obj_draw.sv
// Object tile-row drawer: queues row requests, fetches one ROM word per row and
// writes its 8 pixels to the line buffer, skipping transparent ones.
module jtbubl_obj_draw #(
    parameter int              CW        = 10,
    parameter int              PW        = 4,
    parameter int              BPP       = 4,
    parameter int              LAW       = 9,
    parameter int              QAW       = 2,
    parameter bit              TRANSP_EN = 1'b1,
    parameter logic [BPP-1:0]  TRANSP    = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    jtbubl_obj_draw_if.slave   bus
);
    localparam int DEPTH = 2 ** QAW;
    localparam int EW    = CW + PW + LAW + 6;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAW  = 2'd2;

    logic [EW-1:0]    mem [DEPTH];
    logic [QAW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [QAW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [QAW:0]     count_q, count_d;

    logic [1:0]       state_q, state_d;
    logic [CW+2:0]    rom_addr_q, rom_addr_d;
    logic [PW-1:0]    pal_q, pal_d;
    logic             hflip_q, hflip_d;
    logic             first_q, first_d;
    logic [8*BPP-1:0] data_q, data_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [LAW-1:0]   addr_q, addr_d;

    logic             full, empty, push, pop;
    logic [EW-1:0]    entry_in, head;
    logic [CW-1:0]    h_code;
    logic [PW-1:0]    h_pal;
    logic             h_hflip, h_vflip, h_cont;
    logic [2:0]       h_vrow;
    logic [LAW-1:0]   h_xpos;
    logic [2:0]       pix_idx;
    logic [BPP-1:0]   pix;

    assign full     = (count_q == (QAW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign push     = bus.req && !full;
    assign entry_in = {bus.req_code, bus.req_pal, bus.req_hflip, bus.req_vflip,
                       bus.req_vrow, bus.req_xpos, bus.req_cont};
    assign head     = mem[rd_ptr_q];
    assign {h_code, h_pal, h_hflip, h_vflip, h_vrow, h_xpos, h_cont} = head;

    // Queue storage needs no reset: emptiness is defined by the pointers/count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= entry_in;
    end

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        pal_d      = pal_q;
        hflip_d    = hflip_q;
        first_d    = first_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        pop        = 1'b0;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                first_d = 1'b0;
                // The first FETCH cycle's rom_ok still refers to the old address.
                if (!first_q && bus.rom_ok) begin
                    data_d  = bus.rom_data;
                    cnt_d   = 3'd0;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                cnt_d  = cnt_q + 3'd1;
                addr_d = addr_q + LAW'(1);
                if (cnt_q == 3'd7) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // addr_d already holds the address after the last drawn pixel here.
        if (pop) begin
            rom_addr_d = {h_code, h_vrow ^ {3{h_vflip}}};
            pal_d      = h_pal;
            hflip_d    = h_hflip;
            first_d    = 1'b1;
            if (!h_cont) addr_d = h_xpos;
        end

        rd_ptr_d = pop  ? rd_ptr_q + QAW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + QAW'(1) : wr_ptr_q;
        count_d  = count_q + (QAW+1)'(push) - (QAW+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            rom_addr_q <= '0;
            pal_q      <= '0;
            hflip_q    <= 1'b0;
            first_q    <= 1'b0;
            data_q     <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            pal_q      <= pal_d;
            hflip_q    <= hflip_d;
            first_q    <= first_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
        end
    end

    assign pix_idx       = hflip_q ? ~cnt_q : cnt_q;
    assign pix           = data_q[pix_idx*BPP +: BPP];

    assign bus.full      = full;
    assign bus.busy      = !empty || (state_q != IDLE);
    assign bus.rom_cs    = (state_q == FETCH);
    assign bus.rom_addr  = rom_addr_q;
    assign bus.buf_we    = (state_q == DRAW) && !(TRANSP_EN && (pix == TRANSP));
    assign bus.buf_addr  = addr_q;
    assign bus.buf_din   = {pal_q, pix};
    assign bus.fsm_state = state_q;
endmodule
